// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module     : alu_operand_loader
// Description: Debounced button-driven operand/opcode loader for an external
//              combinational ALU, with registered result and status flags.
// Revision   : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_switches,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_alu_carry,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_res,
  output logic               o_carry,
  output logic               o_zero,
  output logic               o_valid,
  output logic [2:0]         o_loaded
);

  localparam int                NB_CNT     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NB_CNT-1:0] C_CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic [2:0] btn_raw;
  logic [2:0] pulse;

  assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi = gi + 1) begin : g_btn
      logic              sync1_q;
      logic              sync2_q;
      logic              stable_q;
      logic              prev_q;
      logic [NB_CNT-1:0] cnt_q;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          stable_q <= 1'b0;
          prev_q   <= 1'b0;
          cnt_q    <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          prev_q  <= stable_q;
          // Accept the new level on the D-th consecutive mismatching cycle.
          if (sync2_q != stable_q) begin
            if (cnt_q == C_CNT_LAST) begin
              stable_q <= sync2_q;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
      end

      assign pulse[gi] = stable_q & ~prev_q;
    end
  endgenerate

  logic               load_a;
  logic               load_b;
  logic               load_op;
  logic [2:0]         loaded_d;
  logic               capture_d;

  logic [NB_DATA-1:0] alu_a_q;
  logic [NB_DATA-1:0] alu_b_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic [NB_DATA-1:0] res_q;
  logic               carry_q;
  logic               zero_q;
  logic               valid_q;
  logic               capture_q;
  logic [2:0]         loaded_q;

  // Fixed priority A > B > OP; lower simultaneous pulses are dropped.
  always_comb begin
    load_a    = pulse[0];
    load_b    = pulse[1] & ~pulse[0];
    load_op   = pulse[2] & ~pulse[1] & ~pulse[0];
    loaded_d  = loaded_q | {load_op, load_b, load_a};
    capture_d = (load_a | load_b | load_op) && (loaded_d == 3'b111);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
      capture_q <= 1'b0;
      loaded_q  <= 3'b000;
    end else begin
      if (load_a)  alu_a_q  <= i_switches;
      if (load_b)  alu_b_q  <= i_switches;
      if (load_op) alu_op_q <= i_switches[NB_OP-1:0];
      loaded_q  <= loaded_d;
      capture_q <= capture_d;
      // Capture one cycle after the load so the ALU sees the new operands.
      if (capture_q) begin
        res_q   <= i_alu_res;
        carry_q <= i_alu_carry;
        zero_q  <= (i_alu_res == '0);
        valid_q <= 1'b1;
      end
    end
  end

  assign o_alu_a  = alu_a_q;
  assign o_alu_b  = alu_b_q;
  assign o_alu_op = alu_op_q;
  assign o_res    = res_q;
  assign o_carry  = carry_q;
  assign o_zero   = zero_q;
  assign o_valid  = valid_q;
  assign o_loaded = loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_alu_operand_loader
// Description: Scoreboard bench for alu_operand_loader with a behavioural ALU.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int D       = 4;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic [NB_DATA-1:0] sw    = '0;
  logic               btn_a = 1'b0;
  logic               btn_b = 1'b0;
  logic               btn_op = 1'b0;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_carry;
  logic [NB_DATA-1:0] o_a;
  logic [NB_DATA-1:0] o_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] res;
  logic               carry;
  logic               zero;
  logic               valid;
  logic [2:0]         loaded;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NB_DATA:0] alu_model(input logic [NB_DATA-1:0] a,
                                                 input logic [NB_DATA-1:0] b,
                                                 input logic [NB_OP-1:0]   op);
    case (op)
      6'h20:   return {1'b0, a} + {1'b0, b};
      6'h22:   return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  assign {alu_carry, alu_res} = alu_model(o_a, o_b, o_op);

  alu_operand_loader #(
    .NB_DATA(NB_DATA),
    .NB_OP(NB_OP),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_switches(sw),
    .i_btn_a(btn_a),
    .i_btn_b(btn_b),
    .i_btn_op(btn_op),
    .i_alu_res(alu_res),
    .i_alu_carry(alu_carry),
    .o_alu_a(o_a),
    .o_alu_b(o_b),
    .o_alu_op(o_op),
    .o_res(res),
    .o_carry(carry),
    .o_zero(zero),
    .o_valid(valid),
    .o_loaded(loaded)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int                 cyc;
    logic [NB_DATA-1:0] a;
    logic [NB_DATA-1:0] b;
    logic [NB_OP-1:0]   op;
    logic [2:0]         ld;
    logic               v;
    logic [NB_DATA-1:0] r;
    logic               c;
    logic               z;
  } exp_t;

  exp_t sb[$];

  // Reference state of the loader as the bench expects it.
  logic [NB_DATA-1:0] m_a, m_b, m_r;
  logic [NB_OP-1:0]   m_op;
  logic [2:0]         m_ld;
  logic               m_v, m_c, m_z;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_ld = '0; m_v = 0; m_r = '0; m_c = 0; m_z = 0;
  endtask

  task automatic push_exp(input int c);
    exp_t e;
    e.cyc = c; e.a = m_a; e.b = m_b; e.op = m_op; e.ld = m_ld;
    e.v = m_v; e.r = m_r; e.c = m_c; e.z = m_z;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : p_chk
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check_val("sb_late", cyc, e.cyc);
      check_val("alu_a",  32'(o_a),    32'(e.a));
      check_val("alu_b",  32'(o_b),    32'(e.b));
      check_val("alu_op", 32'(o_op),   32'(e.op));
      check_val("loaded", 32'(loaded), 32'(e.ld));
      check_val("valid",  32'(valid),  32'(e.v));
      check_val("res",    32'(res),    32'(e.r));
      check_val("carry",  32'(carry),  32'(e.c));
      check_val("zero",   32'(zero),   32'(e.z));
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_a"},      32'(o_a),    0);
    check_val({tag, "_b"},      32'(o_b),    0);
    check_val({tag, "_op"},     32'(o_op),   0);
    check_val({tag, "_res"},    32'(res),    0);
    check_val({tag, "_carry"},  32'(carry),  0);
    check_val({tag, "_zero"},   32'(zero),   0);
    check_val({tag, "_valid"},  32'(valid),  0);
    check_val({tag, "_loaded"}, 32'(loaded), 0);
  endtask

  // Raise the buttons in mask for hold cycles; expect_load says whether the
  // debounced press should be accepted.
  task automatic press(input logic [2:0] mask, input logic [NB_DATA-1:0] val,
                       input int hold, input bit expect_load);
    int e0;
    @(posedge clk); #1;
    sw = val;
    btn_a = mask[0]; btn_b = mask[1]; btn_op = mask[2];
    e0 = cyc;
    if (expect_load) begin
      if (mask[0])      begin m_a  = val;              m_ld[0] = 1'b1; end
      else if (mask[1]) begin m_b  = val;              m_ld[1] = 1'b1; end
      else              begin m_op = val[NB_OP-1:0];   m_ld[2] = 1'b1; end
      push_exp(e0 + 3 + D);
      if (m_ld == 3'b111) begin
        {m_c, m_r} = alu_model(m_a, m_b, m_op);
        m_z = (m_r == '0);
        m_v = 1'b1;
        push_exp(e0 + 4 + D);
      end
    end
    push_exp(e0 + hold + D + 4);
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      if (k == 5 + D && hold > 5 + D) sw = ~val;
    end
    btn_a = 0; btn_b = 0; btn_op = 0;
    repeat (D + 6) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("rst_init");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency and hold: one load, then switches change while still held.
    press(3'b001, 8'h0F, 16, 1'b1);
    // Glitch shorter than the debounce window on B.
    press(3'b010, 8'h55, 3, 1'b0);

    // Full sequence: A, B, then ADD opcode completes the mask.
    press(3'b001, 8'hF0, 12, 1'b1);
    press(3'b010, 8'h20, 12, 1'b1);
    press(3'b100, 8'h20, 12, 1'b1);
    // Reload B so the sum wraps to zero with carry out.
    press(3'b010, 8'h10, 12, 1'b1);
    // Aligned A and OP presses: only A is serviced.
    press(3'b101, 8'h05, 12, 1'b1);

    for (int k = 0; k < 30 && sb.size() > 0; k++) @(posedge clk);
    check_val("sb_empty", sb.size(), 0);

    // Asynchronous reset mid-cycle.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
